axi_beat_uart_framer: RTL and testbench

- Downstream stage of the debug AXI reader path.
- Consumes 256-bit AXI read-data beats for one window dump and serializes them into a framed byte stream for the PC UART transmitter.
- Frame format: header, tag, payload bytes, XOR checksum.
- Decouples the AXI burst rate from the byte-at-a-time UART rate through a single-beat holding register with valid/ready on both sides.

---
 rtl/framer_pkg.sv | 27 ++
 rtl/beat_shift_reg.sv | 46 ++++
 rtl/axi_beat_uart_framer.sv | 168 ++++++++++++++++
 tb/tb_axi_beat_uart_framer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/framer_pkg.sv
// Shared definitions for the AXI-beat-to-UART framer: FSM state encoding,
// default sync bytes and the frame-length helper.
package framer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    TAG   = 3'd3,
    LOAD  = 3'd4,
    SHIFT = 3'd5,
    CSUM  = 3'd6
  } state_t;

  localparam logic [7:0] HEADER0_DEFAULT = 8'hAA;
  localparam logic [7:0] HEADER1_DEFAULT = 8'h55;

  // Two sync bytes plus the tag lead every frame; one checksum byte ends it.
  localparam int HEADER_BYTES = 3;
  localparam int CSUM_BYTES   = 1;

  // Total bytes on the wire for a full-length frame.
  function automatic int frame_len(input int data_byte_width, input int data_depth);
    return HEADER_BYTES + data_byte_width * data_depth + CSUM_BYTES;
  endfunction

endpackage

// File: rtl/beat_shift_reg.sv
// Single-beat holding register with a little-endian byte selector.
// i_load captures a beat and rewinds to byte 0; i_advance steps one byte.
module beat_shift_reg #(
  parameter int DATA_BYTE_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_load,
  input  logic [DATA_BYTE_WIDTH*8-1:0] i_load_data,
  input  logic                         i_advance,
  output logic [7:0]                   o_byte,
  output logic                         o_last_byte
);

  localparam int IDX_W = $clog2(DATA_BYTE_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTE_WIDTH - 1);

  logic [DATA_BYTE_WIDTH-1:0][7:0] r_hold;
  logic [IDX_W-1:0]                r_byte_idx;

  // Capture the accepted beat; byte 0 sits in bits [7:0].
  // NOTE: pure datapath storage is not reset -- its contents are only ever
  // observed after a load, so a reset would cost routing and buy nothing.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_hold <= i_load_data;
    end
  end

  // Byte pointer: rewinds on load, steps on each accepted byte, wraps naturally.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_idx <= '0;
    end else if (i_load) begin
      r_byte_idx <= '0;
    end else if (i_advance) begin
      r_byte_idx <= r_byte_idx + IDX_W'(1);
    end
  end

  assign o_byte      = r_hold[r_byte_idx];
  assign o_last_byte = (r_byte_idx == LAST_IDX);

endmodule

// File: rtl/axi_beat_uart_framer.sv
// Serializes one window dump of AXI read beats into a framed UART byte
// stream: HEADER0, HEADER1, tag, payload (little-endian per beat), XOR csum.
// A single holding register decouples the AXI burst from the byte stream.
module axi_beat_uart_framer
  import framer_pkg::*;
#(
  parameter int         DATA_BYTE_WIDTH = 32,
  parameter int         DATA_DEPTH      = 16,
  parameter logic [7:0] HEADER0         = HEADER0_DEFAULT,
  parameter logic [7:0] HEADER1         = HEADER1_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic [7:0]                   frame_tag,
  input  logic [DATA_BYTE_WIDTH*8-1:0] beat_data,
  input  logic                         beat_valid,
  input  logic                         beat_last,
  output logic                         beat_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err_len
);

  localparam int BCNT_W = $clog2(DATA_DEPTH + 1);
  localparam logic [BCNT_W-1:0] DEPTH_CNT = BCNT_W'(DATA_DEPTH);

  state_t              r_state;
  state_t              w_next_state;
  logic [7:0]          r_tag;
  logic [7:0]          r_csum;
  logic [BCNT_W-1:0]   r_beat_cnt;
  logic                r_last;
  logic                r_beat_ready;
  logic                r_frame_done;
  logic                r_err_len;

  logic                w_tx_fire;
  logic                w_beat_fire;
  logic                w_start;
  logic                w_advance;
  logic                w_payload_end;
  logic                w_end_frame;
  logic                w_len_err;
  logic [7:0]          w_shift_byte;
  logic                w_last_byte;
  logic [7:0]          w_tx_data;

  assign w_tx_fire     = tx_valid && tx_ready;
  assign w_beat_fire   = beat_valid && r_beat_ready;
  assign w_start       = (r_state == IDLE) && frame_start;
  assign w_advance     = (r_state == SHIFT) && w_tx_fire;
  assign w_payload_end = w_advance && w_last_byte;
  // The frame ends on the burst's own last flag or when the window is full.
  assign w_end_frame   = r_last || (r_beat_cnt == DEPTH_CNT);
  // Last arriving early (short burst) or never arriving (overlong burst).
  assign w_len_err     = (r_last && (r_beat_cnt != DEPTH_CNT)) ||
                         (!r_last && (r_beat_cnt == DEPTH_CNT));

  beat_shift_reg #(
    .DATA_BYTE_WIDTH (DATA_BYTE_WIDTH)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_beat_fire),
    .i_load_data (beat_data),
    .i_advance   (w_advance),
    .o_byte      (w_shift_byte),
    .o_last_byte (w_last_byte)
  );

  // Next-state logic: every byte-emitting state waits for its UART handshake.
  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (frame_start)   w_next_state = HDR0;
      HDR0:    if (w_tx_fire)     w_next_state = HDR1;
      HDR1:    if (w_tx_fire)     w_next_state = TAG;
      TAG:     if (w_tx_fire)     w_next_state = LOAD;
      LOAD:    if (w_beat_fire)   w_next_state = SHIFT;
      SHIFT:   if (w_payload_end) w_next_state = w_end_frame ? CSUM : LOAD;
      CSUM:    if (w_tx_fire)     w_next_state = IDLE;
      default:                    w_next_state = IDLE;
    endcase
  end

  // State register plus the registered beat_ready, raised on entry to LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beat_ready <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_beat_ready <= (w_next_state == LOAD);
    end
  end

  // Per-frame bookkeeping: tag, beat count and the latched last flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag      <= '0;
      r_beat_cnt <= '0;
      r_last     <= 1'b0;
    end else if (w_start) begin
      r_tag      <= frame_tag;
      r_beat_cnt <= '0;
      r_last     <= 1'b0;
    end else if (w_beat_fire) begin
      r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
      r_last     <= beat_last;
    end
  end

  // Running XOR over the tag and every payload byte actually sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if ((r_state == TAG) && w_tx_fire) begin
      r_csum <= r_csum ^ r_tag;
    end else if (w_advance) begin
      r_csum <= r_csum ^ w_shift_byte;
    end
  end

  // Completion pulse after the checksum leaves, and the sticky length flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_frame_done <= (r_state == CSUM) && w_tx_fire;
      if (w_start) begin
        r_err_len <= 1'b0;
      end else if (w_payload_end && w_len_err) begin
        r_err_len <= 1'b1;
      end
    end
  end

  // Byte presented to the UART; held by the state/pointer until accepted.
  always_comb begin
    w_tx_data = 8'h00;
    unique case (r_state)
      HDR0:    w_tx_data = HEADER0;
      HDR1:    w_tx_data = HEADER1;
      TAG:     w_tx_data = r_tag;
      SHIFT:   w_tx_data = w_shift_byte;
      CSUM:    w_tx_data = r_csum;
      default: w_tx_data = 8'h00;
    endcase
  end

  assign tx_data    = w_tx_data;
  assign tx_valid   = (r_state == HDR0) || (r_state == HDR1) || (r_state == TAG) ||
                      (r_state == SHIFT) || (r_state == CSUM);
  assign busy       = (r_state != IDLE);
  assign beat_ready = r_beat_ready;
  assign frame_done = r_frame_done;
  assign err_len    = r_err_len;

endmodule

// File: tb/tb_axi_beat_uart_framer.sv
// Self-checking bench for axi_beat_uart_framer: table of frame scenarios
// (full, backpressure, short, missing last, busy restart) plus hand-written
// sequences for reset, idle beats, quick restart and mid-frame reset.
module tb_axi_beat_uart_framer;

  logic         clk;
  logic         rst_n;
  logic         frame_start;
  logic [7:0]   frame_tag;
  logic [255:0] beat_data;
  logic         beat_valid;
  logic         beat_last;
  logic         beat_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         frame_done;
  logic         err_len;

  axi_beat_uart_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_tag   (frame_tag),
    .beat_data   (beat_data),
    .beat_valid  (beat_valid),
    .beat_last   (beat_last),
    .beat_ready  (beat_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_len     (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tag;
    int         n_off;     // beats offered by the source
    int         last_idx;  // index of the beat carrying last, -1 for none
    logic       bp;        // random tx_ready backpressure
    int         mid_byte;  // issue a second frame_start after this many bytes, -1 none
    int         exp_len;
    logic       exp_err;
    logic [7:0] exp_csum;
    int         exp_acc;   // beats the DUT must accept
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] src_beats[0:31];
  int           src_n    = 0;
  int           src_idx  = 0;
  int           src_last = -1;
  logic         bp_mode  = 1'b0;

  logic [7:0]   got_q[$];
  int           done_cnt  = 0;
  int           stab_viol = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] beat_pat(input int k);
    logic [255:0] b;
    for (int j = 0; j < 32; j++) b[j*8 +: 8] = 8'((k * 32 + j) & 255);
    return b;
  endfunction

  // Beat source, tx_ready driver and byte/pulse monitor. Sampling happens at
  // the falling edge; inputs change 1 time unit after the rising edge.
  initial begin
    logic       f_beat;
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      f_beat = beat_valid && beat_ready;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (frame_done) done_cnt++;
      if (prev_stall && tx_valid && (tx_data !== prev_data)) stab_viol++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      @(posedge clk);
      #1;
      if (f_beat) src_idx++;
      if (src_idx < src_n) begin
        beat_valid = 1'b1;
        beat_data  = src_beats[src_idx];
        beat_last  = (src_idx == src_last);
      end else begin
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_last  = 1'b0;
      end
      tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic load_src(input int n, input int last_idx);
    for (int k = 0; k < n; k++) src_beats[k] = beat_pat(k);
    src_n    = n;
    src_idx  = 0;
    src_last = last_idx;
  endtask

  // Called at rising edge + 3; returns at rising edge + 3 after sampling.
  task automatic start_frame(input logic [7:0] tag);
    frame_tag   = tag;
    frame_start = 1'b1;
    @(posedge clk);
    #3;
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input int vi, input vec_t v);
    logic mid_done;
    mid_done = 1'b0;
    bp_mode  = v.bp;
    load_src(v.n_off, v.last_idx);
    got_q.delete();
    done_cnt  = 0;
    stab_viol = 0;
    @(posedge clk);
    #3;
    start_frame(v.tag);
    check($sformatf("v%0d_err_clear", vi), err_len, 0);
    for (int c = 0; c < 8000; c++) begin
      if (done_cnt != 0) break;
      @(posedge clk);
      #3;
      if (v.mid_byte >= 0 && !mid_done && got_q.size() >= v.mid_byte) begin
        start_frame(8'h09);
        mid_done = 1'b1;
      end
    end
    check($sformatf("v%0d_done_seen", vi), int'(done_cnt != 0), 1);
    repeat (4) @(posedge clk);
    #3;
  endtask

  task automatic verify(input int vi, input vec_t v);
    logic [7:0] exp_q[$];
    int         mism;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(v.tag);
    for (int k = 0; k < v.exp_acc; k++)
      for (int j = 0; j < 32; j++) exp_q.push_back(8'((k * 32 + j) & 255));
    exp_q.push_back(v.exp_csum);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check($sformatf("v%0d_len", vi), got_q.size(), v.exp_len);
    check($sformatf("v%0d_byte_mismatches", vi), mism, 0);
    check($sformatf("v%0d_csum", vi), (got_q.size() > 0) ? int'(got_q[got_q.size()-1]) : -1,
          v.exp_csum);
    check($sformatf("v%0d_err_len", vi), err_len, v.exp_err);
    check($sformatf("v%0d_done_count", vi), done_cnt, 1);
    check($sformatf("v%0d_beats_accepted", vi), src_idx, v.exp_acc);
    check($sformatf("v%0d_stable_under_stall", vi), stab_viol, 0);
    check($sformatf("v%0d_beat_ready_after", vi), beat_ready, 0);
    check($sformatf("v%0d_busy_after", vi), busy, 0);
  endtask

  initial begin
    int n_before;
    //            tag    off last bp  mid  len  err  csum  acc
    vecs[0] = '{8'h07, 16, 15, 1'b0, -1, 516, 1'b0, 8'h07, 16};  // full frame
    vecs[1] = '{8'h07, 16, 15, 1'b1, -1, 516, 1'b0, 8'h07, 16};  // backpressure
    vecs[2] = '{8'h02,  3,  2, 1'b0, -1, 100, 1'b1, 8'h02,  3};  // short burst
    vecs[3] = '{8'h5A, 17, -1, 1'b0, -1, 516, 1'b1, 8'h5A, 16};  // missing last
    vecs[4] = '{8'h07, 16, 15, 1'b0, 100, 516, 1'b0, 8'h07, 16}; // start while busy
    vecs[5] = '{8'h3C,  5,  4, 1'b1, -1, 164, 1'b1, 8'h3C,  5};  // short + backpressure

    rst_n       = 1'b0;
    frame_start = 1'b0;
    frame_tag   = 8'h00;
    beat_data   = '0;
    beat_valid  = 1'b0;
    beat_last   = 1'b0;
    tx_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_beat_ready", beat_ready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_len", err_len, 0);
    rst_n = 1'b1;

    // A beat offered outside a frame must not be taken.
    load_src(1, 0);
    repeat (6) @(posedge clk);
    #3;
    check("idle_beat_not_taken", src_idx, 0);
    check("idle_beat_ready", beat_ready, 0);
    check("idle_tx_valid", tx_valid, 0);
    src_n = 0;
    repeat (2) @(posedge clk);
    #3;

    for (int vi = 0; vi < 6; vi++) begin
      run_frame(vi, vecs[vi]);
      verify(vi, vecs[vi]);
    end

    // Restart right after a completed frame: header is up the next cycle.
    bp_mode = 1'b0;
    load_src(16, 15);
    got_q.delete();
    done_cnt = 0;
    start_frame(8'h11);
    check("restart_tx_valid", tx_valid, 1);
    check("restart_hdr0", tx_data, 8'hAA);
    check("restart_busy", busy, 1);

    // Abort at byte 200 with an asynchronous reset.
    for (int c = 0; c < 2000; c++) begin
      if (got_q.size() >= 200) break;
      @(posedge clk);
      #3;
    end
    check("reach_byte_200", int'(got_q.size() >= 200), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_tx_valid", tx_valid, 0);
    check("abort_tx_data", tx_data, 0);
    check("abort_busy", busy, 0);
    check("abort_beat_ready", beat_ready, 0);
    src_n = 0;
    n_before = got_q.size();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_more_bytes", got_q.size(), n_before);

    // Clean full frame after the abort.
    run_frame(6, vecs[0]);
    verify(6, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
